// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer placed ahead of the rename table.
// Allocates up to two tags per cycle at dispatch and records each entry's destination
// register and result. It retires completed entries in program order through
// registered outputs. A resolved-branch flush rolls the tail back to just after the branch.
// Build option: define ROB_DUAL_RETIRE_EN to retire up to two entries per cycle.
// When it is undefined the buffer retires at most one entry per cycle, and every
// slot-1 retire output is tied to 0.
module reorder_buffer #(
  parameter int  DEPTH = 32,
  parameter int  RW    = 5,
  parameter int  DW    = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  // dispatch / allocate
  input  logic          alloc0,
  input  logic          alloc1,
  input  logic [RW-1:0] alloc_reg_addr0,
  input  logic [RW-1:0] alloc_reg_addr1,
  input  logic          alloc_wr0,
  input  logic          alloc_wr1,
  input  logic          alloc_spec0,
  input  logic          alloc_spec1,
  output logic [AW-1:0] alloc_rob_addr0,
  output logic [AW-1:0] alloc_rob_addr1,
  output logic          alloc_ready,
  // completion
  input  logic          wb0,
  input  logic          wb1,
  input  logic [AW-1:0] wb_rob_addr0,
  input  logic [AW-1:0] wb_rob_addr1,
  input  logic [DW-1:0] wb_data0,
  input  logic [DW-1:0] wb_data1,
  // branch recovery
  input  logic          flush,
  input  logic [AW-1:0] flush_rob_addr,
  // retire
  output logic          retire0,
  output logic          retire1,
  output logic [RW-1:0] retire_reg_addr0,
  output logic [RW-1:0] retire_reg_addr1,
  output logic [AW-1:0] retire_rob_addr0,
  output logic [AW-1:0] retire_rob_addr1,
  output logic [DW-1:0] retire_data0,
  output logic [DW-1:0] retire_data1,
  output logic          retire_wr0,
  output logic          retire_wr1,
  output logic          retire_spec0,
  output logic          retire_spec1,
  output logic [AW:0]   count
);

  localparam int CW = AW + 1;

  typedef struct packed {
    logic          fire;
    logic          wr;
    logic          spec;
    logic [RW-1:0] reg_addr;
    logic [AW-1:0] rob_addr;
    logic [DW-1:0] data;
  } retire_t;

  // Pointers and per-entry status
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d, done_q, done_d, drop_mask;

  // Per-entry payload
  logic [DEPTH-1:0] wr_q, spec_q;
  logic [RW-1:0]    reg_addr_q [DEPTH];
  logic [DW-1:0]    data_q     [DEPTH];

  logic          do_alloc0, do_alloc1, wb0_ok, wb1_ok, ret0, ret1;
  logic [AW-1:0] head_p1, tail_p1, dropped;
  logic [CW-1:0] alloc_n, ret_n, drop_n;

  retire_t ret0_q;

  assign head_p1         = head_q + AW'(1);
  assign tail_p1         = tail_q + AW'(1);
  assign alloc_rob_addr0 = tail_q;
  assign alloc_rob_addr1 = tail_p1;
  assign alloc_ready     = (count_q <= CW'(DEPTH - 2));
  assign count           = count_q;

  // A flush cycle never allocates. The younger slots are being discarded anyway.
  assign do_alloc0 = alloc0 && alloc_ready && !flush;
  assign do_alloc1 = do_alloc0 && alloc1;

  // A completion that targets a flushed (invalid) entry is ignored.
  assign wb0_ok = wb0 && vld_q[wb_rob_addr0];
  assign wb1_ok = wb1 && vld_q[wb_rob_addr1];

  assign ret0 = vld_q[head_q] && done_q[head_q];
`ifdef ROB_DUAL_RETIRE_EN
  assign ret1 = ret0 && vld_q[head_p1] && done_q[head_p1];
`else
  assign ret1 = 1'b0;
`endif

  // Entries strictly younger than the branch, up to the old tail. The modular
  // subtraction also gives the correct answer when the buffer is full.
  assign dropped = tail_q - flush_rob_addr - AW'(1);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_drop
    assign drop_mask[gi] = flush && ((AW'(gi) - flush_rob_addr - AW'(1)) < dropped);
  end

  assign alloc_n = CW'(do_alloc0) + CW'(do_alloc1);
  assign ret_n   = CW'(ret0) + CW'(ret1);
  assign drop_n  = flush ? CW'(dropped) : '0;
  assign count_d = count_q + alloc_n - ret_n - drop_n;
  assign head_d  = head_q + AW'(ret_n);
  assign tail_d  = flush ? (flush_rob_addr + AW'(1)) : (tail_q + AW'(alloc_n));

  // Next-state valid/done vectors: completion, retire, flush, then allocation.
  always_comb begin
    // NOTE: copy the current state first so that every bit has a value on every
    // path. Otherwise this block would infer latches.
    vld_d  = vld_q;
    done_d = done_q;
    // NOTE: blocking '=' is used here because later statements must see the
    // earlier updates. Clocked blocks use '<=' only.
    if (wb0_ok) done_d[wb_rob_addr0] = 1'b1;
    if (wb1_ok) done_d[wb_rob_addr1] = 1'b1;
    if (ret0)   vld_d[head_q]        = 1'b0;
    if (ret1)   vld_d[head_p1]       = 1'b0;
    vld_d = vld_d & ~drop_mask;
    if (do_alloc0) begin
      vld_d[tail_q]  = 1'b1;
      done_d[tail_q] = 1'b0;
    end
    if (do_alloc1) begin
      vld_d[tail_p1]  = 1'b1;
      done_d[tail_p1] = 1'b0;
    end
  end

  // Control state: pointers, occupancy and per-entry valid/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  // Payload storage: fields are captured at allocate and results at writeback.
  // NOTE: the payload arrays have no reset. Nothing reads a field until its entry
  // is valid, and valid is always written together with the field.
  always_ff @(posedge clk) begin
    if (do_alloc0) begin
      reg_addr_q[tail_q] <= alloc_reg_addr0;
      wr_q[tail_q]       <= alloc_wr0;
      spec_q[tail_q]     <= alloc_spec0;
    end
    if (do_alloc1) begin
      reg_addr_q[tail_p1] <= alloc_reg_addr1;
      wr_q[tail_p1]       <= alloc_wr1;
      spec_q[tail_p1]     <= alloc_spec1;
    end
    if (wb0_ok) data_q[wb_rob_addr0] <= wb_data0;
    if (wb1_ok) data_q[wb_rob_addr1] <= wb_data1;
  end

  // Retire slot 0 register. The strobe follows ret0 every cycle, and the fields
  // are loaded only when an entry retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret0_q <= '0;
    end else begin
      ret0_q.fire <= ret0;
      if (ret0) begin
        ret0_q.wr       <= wr_q[head_q];
        ret0_q.spec     <= spec_q[head_q];
        ret0_q.reg_addr <= reg_addr_q[head_q];
        ret0_q.rob_addr <= head_q;
        ret0_q.data     <= data_q[head_q];
      end
    end
  end

  assign retire0          = ret0_q.fire;
  assign retire_wr0       = ret0_q.wr;
  assign retire_spec0     = ret0_q.spec;
  assign retire_reg_addr0 = ret0_q.reg_addr;
  assign retire_rob_addr0 = ret0_q.rob_addr;
  assign retire_data0     = ret0_q.data;

`ifdef ROB_DUAL_RETIRE_EN
  retire_t ret1_q;

  // Retire slot 1 register: the entry after head, which only retires together with slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret1_q <= '0;
    end else begin
      ret1_q.fire <= ret1;
      if (ret1) begin
        ret1_q.wr       <= wr_q[head_p1];
        ret1_q.spec     <= spec_q[head_p1];
        ret1_q.reg_addr <= reg_addr_q[head_p1];
        ret1_q.rob_addr <= head_p1;
        ret1_q.data     <= data_q[head_p1];
      end
    end
  end

  assign retire1          = ret1_q.fire;
  assign retire_wr1       = ret1_q.wr;
  assign retire_spec1     = ret1_q.spec;
  assign retire_reg_addr1 = ret1_q.reg_addr;
  assign retire_rob_addr1 = ret1_q.rob_addr;
  assign retire_data1     = ret1_q.data;
`else
  assign retire1          = 1'b0;
  assign retire_wr1       = 1'b0;
  assign retire_spec1     = 1'b0;
  assign retire_reg_addr1 = '0;
  assign retire_rob_addr1 = '0;
  assign retire_data1     = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized and directed stimulus for reorder_buffer.
// The reference model is a program-ordered queue of live entries. The expected
// retire records go into a scoreboard queue, and a negedge monitor consumes them.
module tb_reorder_buffer;
  localparam int DEPTH = 32;
  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int AW    = 5;
`ifdef ROB_DUAL_RETIRE_EN
  localparam int NRET = 2;
`else
  localparam int NRET = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alloc0, alloc1, alloc_wr0, alloc_wr1, alloc_spec0, alloc_spec1;
  logic [RW-1:0] alloc_reg_addr0, alloc_reg_addr1;
  logic [AW-1:0] alloc_rob_addr0, alloc_rob_addr1;
  logic          alloc_ready;
  logic          wb0, wb1;
  logic [AW-1:0] wb_rob_addr0, wb_rob_addr1;
  logic [DW-1:0] wb_data0, wb_data1;
  logic          flush;
  logic [AW-1:0] flush_rob_addr;
  logic          retire0, retire1, retire_wr0, retire_wr1, retire_spec0, retire_spec1;
  logic [RW-1:0] retire_reg_addr0, retire_reg_addr1;
  logic [AW-1:0] retire_rob_addr0, retire_rob_addr1;
  logic [DW-1:0] retire_data0, retire_data1;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .RW(RW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .alloc0(alloc0), .alloc1(alloc1),
    .alloc_reg_addr0(alloc_reg_addr0), .alloc_reg_addr1(alloc_reg_addr1),
    .alloc_wr0(alloc_wr0), .alloc_wr1(alloc_wr1),
    .alloc_spec0(alloc_spec0), .alloc_spec1(alloc_spec1),
    .alloc_rob_addr0(alloc_rob_addr0), .alloc_rob_addr1(alloc_rob_addr1),
    .alloc_ready(alloc_ready),
    .wb0(wb0), .wb1(wb1), .wb_rob_addr0(wb_rob_addr0), .wb_rob_addr1(wb_rob_addr1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .flush(flush), .flush_rob_addr(flush_rob_addr),
    .retire0(retire0), .retire1(retire1),
    .retire_reg_addr0(retire_reg_addr0), .retire_reg_addr1(retire_reg_addr1),
    .retire_rob_addr0(retire_rob_addr0), .retire_rob_addr1(retire_rob_addr1),
    .retire_data0(retire_data0), .retire_data1(retire_data1),
    .retire_wr0(retire_wr0), .retire_wr1(retire_wr1),
    .retire_spec0(retire_spec0), .retire_spec1(retire_spec1),
    .count(count)
  );

  typedef struct {
    int            tag;
    logic [RW-1:0] rd;
    logic          wr;
    logic          spec;
    logic          done;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct packed {
    logic          a0, a1;
    logic [RW-1:0] r0, r1;
    logic          w0, w1, s0, s1;
    logic          wb0, wb1;
    logic [AW-1:0] wt0, wt1;
    logic [DW-1:0] wd0, wd1;
    logic          fl;
    logic [AW-1:0] ft;
  } stim_t;

  ent_t       rob[$];      // live entries, oldest first
  int         m_tail;      // next tag to allocate
  logic [44:0] exp_q[$];   // {slot, tag, rd, wr, spec, data}
  int         n_pass = 0;
  int         n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  function automatic logic [44:0] pack(input int slot, input ent_t e);
    return {1'(slot), AW'(e.tag), e.rd, e.wr, e.spec, e.data};
  endfunction

  function automatic int ret_count();
    int n = 0;
    while (n < NRET && n < rob.size() && rob[n].done) n++;
    return n;
  endfunction

  task automatic model_wb(input logic [AW-1:0] t, input logic [DW-1:0] d);
    for (int i = 0; i < rob.size(); i++)
      if (rob[i].tag == int'(t)) begin
        rob[i].done = 1'b1;
        rob[i].data = d;
      end
  endtask

  task automatic model_alloc(input logic [RW-1:0] r, input logic w, input logic sp);
    ent_t e;
    e.tag = m_tail; e.rd = r; e.wr = w; e.spec = sp; e.done = 1'b0; e.data = '0;
    rob.push_back(e);
    m_tail = (m_tail + 1) % DEPTH;
  endtask

  // Apply one cycle of spec rules to the model, and queue the retires it predicts.
  task automatic model_step(input stim_t s);
    int n, size0, k;
    size0 = rob.size();
    n = ret_count();
    for (int i = 0; i < n; i++) exp_q.push_back(pack(i, rob[i]));
    if (s.fl) begin
      k = -1;
      for (int i = 0; i < rob.size(); i++) if (rob[i].tag == int'(s.ft)) k = i;
      while (rob.size() > k + 1) rob.delete(rob.size() - 1);
      m_tail = (int'(s.ft) + 1) % DEPTH;
    end
    for (int i = 0; i < n; i++) rob.delete(0);
    if (s.wb0) model_wb(s.wt0, s.wd0);
    if (s.wb1) model_wb(s.wt1, s.wd1);
    if (s.a0 && size0 <= DEPTH - 2 && !s.fl) begin
      model_alloc(s.r0, s.w0, s.s0);
      if (s.a1) model_alloc(s.r1, s.w1, s.s1);
    end
  endtask

  task automatic drive(input stim_t s);
    alloc0 = s.a0; alloc1 = s.a1;
    alloc_reg_addr0 = s.r0; alloc_reg_addr1 = s.r1;
    alloc_wr0 = s.w0; alloc_wr1 = s.w1; alloc_spec0 = s.s0; alloc_spec1 = s.s1;
    wb0 = s.wb0; wb1 = s.wb1; wb_rob_addr0 = s.wt0; wb_rob_addr1 = s.wt1;
    wb_data0 = s.wd0; wb_data1 = s.wd1;
    flush = s.fl; flush_rob_addr = s.ft;
  endtask

  // One clock: update the model, drive the inputs, then check occupancy and tags after the edge.
  task automatic step(input stim_t s);
    model_step(s);
    drive(s);
    @(posedge clk);
    #1;
    check("count", 64'(count), 64'(rob.size()));
    check("alloc_ready", 64'(alloc_ready), 64'(rob.size() <= DEPTH - 2));
    check("alloc_rob_addr0", 64'(alloc_rob_addr0), 64'(m_tail));
    check("alloc_rob_addr1", 64'(alloc_rob_addr1), 64'((m_tail + 1) % DEPTH));
  endtask

  task automatic do_reset();
    drive('0);
    reset = 1'b0;
    rob.delete();
    exp_q.delete();
    m_tail = 0;
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_retire0", 64'(retire0), 64'(0));
    check("rst_retire1", 64'(retire1), 64'(0));
    check("rst_alloc_rob_addr0", 64'(alloc_rob_addr0), 64'(0));
    check("rst_alloc_rob_addr1", 64'(alloc_rob_addr1), 64'(1));
    check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic stim_t alloc_st(input bit dual, input logic [RW-1:0] r0, input logic [RW-1:0] r1);
    stim_t s = '0;
    s.a0 = 1'b1; s.a1 = dual; s.r0 = r0; s.r1 = r1;
    s.w0 = r0[0]; s.w1 = ~r1[0]; s.s0 = r0[1]; s.s1 = r1[1];
    return s;
  endfunction

  function automatic stim_t wb_st(input int t0, input int t1);
    stim_t s = '0;
    s.wb0 = (t0 >= 0); s.wt0 = AW'(t0); s.wd0 = $urandom;
    s.wb1 = (t1 >= 0); s.wt1 = AW'(t1); s.wd1 = $urandom;
    return s;
  endfunction

  // Complete the oldest outstanding entries until the buffer empties, with a cycle bound.
  task automatic drain();
    int guard = 0;
    int t[2];
    int n;
    while (rob.size() > 0 && guard < 200) begin
      n = 0; t[0] = -1; t[1] = -1;
      for (int i = 0; i < rob.size() && n < 2; i++)
        if (!rob[i].done) begin t[n] = rob[i].tag; n++; end
      step(wb_st(t[0], t[1]));
      guard++;
    end
    check("drain_count", 64'(count), 64'(0));
    step('0);
    step('0);
  endtask

  function automatic stim_t rand_stim(input int wb_pct);
    stim_t s = '0;
    int lo;
    s.a0 = ($urandom_range(0, 3) != 0);
    s.a1 = s.a0 && ($urandom_range(0, 1) == 1);
    s.r0 = RW'($urandom); s.r1 = RW'($urandom);
    s.w0 = 1'($urandom); s.w1 = 1'($urandom); s.s0 = 1'($urandom); s.s1 = 1'($urandom);
    s.wd0 = $urandom; s.wd1 = $urandom;
    if (rob.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
      s.wb0 = 1'b1; s.wt0 = AW'(rob[$urandom_range(0, rob.size() - 1)].tag);
    end else if ($urandom_range(0, 7) == 0) begin
      s.wb0 = 1'b1; s.wt0 = AW'($urandom);
    end
    if (rob.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
      s.wb1 = 1'b1; s.wt1 = AW'(rob[$urandom_range(0, rob.size() - 1)].tag);
    end
    if (s.wb0 && s.wb1 && s.wt0 == s.wt1) s.wb1 = 1'b0;
    if (rob.size() > 0 && $urandom_range(0, 29) == 0) begin
      lo = (ret_count() > 0) ? ret_count() - 1 : 0;
      s.fl = 1'b1;
      s.ft = AW'(rob[$urandom_range(lo, rob.size() - 1)].tag);
    end
    return s;
  endfunction

  // Scoreboard monitor: every retire strobe must match the oldest expected record.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (retire0 === 1'b1) begin
        if (exp_q.size() == 0) check("retire0_spurious", 64'(retire0), 64'(0));
        else check("retire0_record",
                   64'({1'b0, retire_rob_addr0, retire_reg_addr0, retire_wr0, retire_spec0, retire_data0}),
                   64'(exp_q.pop_front()));
      end
      if (retire1 === 1'b1) begin
        if (exp_q.size() == 0) check("retire1_spurious", 64'(retire1), 64'(0));
        else check("retire1_record",
                   64'({1'b1, retire_rob_addr1, retire_reg_addr1, retire_wr1, retire_spec1, retire_data1}),
                   64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive('0);
    m_tail = 0;
    repeat (2) @(posedge clk);
    #1;
    check("por_count", 64'(count), 64'(0));
    check("por_alloc_ready", 64'(alloc_ready), 64'(1));
    check("por_retire0", 64'(retire0), 64'(0));
    reset = 1'b1;

    // Reset mid-run with 7 live entries and a retire in progress.
    for (int i = 0; i < 4; i++) step(alloc_st(1'b1, RW'(2 * i), RW'(2 * i + 1)));
    step(wb_st(0, -1));
    step('0);
    check("midrun_count", 64'(count), 64'(7));
    do_reset();
    step(alloc_st(1'b0, RW'(5), RW'(0)));
    drain();

    // Fill completely, try one more dual allocate, then flush at tail-1 while retiring head.
    do_reset();
    for (int i = 0; i < 16; i++) step(alloc_st(1'b1, RW'(2 * i), RW'(2 * i + 1)));
    step(alloc_st(1'b1, RW'(7), RW'(9)));
    step(wb_st(0, -1));
    begin
      stim_t s = '0;
      s.fl = 1'b1; s.ft = AW'(31);
      step(s);
    end
    check("full_flush_count", 64'(count), 64'(31));
    drain();

    // Out-of-order completion: tags 3, 1, 0. Tag 2 then blocks retirement.
    do_reset();
    step(alloc_st(1'b1, RW'(1), RW'(2)));
    step(alloc_st(1'b1, RW'(3), RW'(4)));
    step(wb_st(3, -1));
    step(wb_st(1, -1));
    step(wb_st(0, -1));
    repeat (3) step('0);
    check("ooo_count", 64'(count), 64'(2));
    drain();

    // Wrap-around: allocate tags 30, 31, 0, 1.
    do_reset();
    for (int i = 0; i < 15; i++) step(alloc_st(1'b1, RW'(i), RW'(i + 16)));
    drain();
    step(alloc_st(1'b1, RW'(10), RW'(11)));
    step(alloc_st(1'b1, RW'(12), RW'(13)));
    step(wb_st(30, 31));
    step(wb_st(0, 1));
    repeat (3) step('0);
    drain();

    // Flush at tag 7 with tags 5..12 live. A same-cycle allocate is dropped, and a late wb to tag 9 is ignored.
    do_reset();
    step(alloc_st(1'b1, RW'(1), RW'(2)));
    step(alloc_st(1'b1, RW'(3), RW'(4)));
    step(alloc_st(1'b0, RW'(5), RW'(0)));
    drain();
    for (int i = 0; i < 4; i++) step(alloc_st(1'b1, RW'(20 + i), RW'(24 + i)));
    begin
      stim_t s = alloc_st(1'b1, RW'(30), RW'(31));
      s.fl = 1'b1; s.ft = AW'(7);
      step(s);
    end
    check("flush_count", 64'(count), 64'(3));
    check("flush_tail", 64'(alloc_rob_addr0), 64'(8));
    step(wb_st(9, -1));
    drain();

    // Randomized traffic: a filling phase, then a draining phase.
    do_reset();
    for (int i = 0; i < 1500; i++) step(rand_stim(25));
    for (int i = 0; i < 1500; i++) step(rand_stim(80));
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
